// File: rtl/seq_bit_tx_if.sv
// rtl/seq_bit_tx_if.sv - parallel word handshake in, x/y serial link out, for seq_bit_tx.
// Optional match_cnt member is present only when SEQ_BIT_TX_CNT_EN is defined.
interface seq_bit_tx_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             x;
  logic             x_valid;
  logic             busy;
  logic             word_done;
  logic             match_exp;
`ifdef SEQ_BIT_TX_CNT_EN
  logic [15:0]      match_cnt;

  modport master (
    output din, din_valid,
    input  din_ready, x, x_valid, busy, word_done, match_exp, match_cnt
  );
  modport slave (
    input  din, din_valid,
    output din_ready, x, x_valid, busy, word_done, match_exp, match_cnt
  );
`else
  modport master (
    output din, din_valid,
    input  din_ready, x, x_valid, busy, word_done, match_exp
  );
  modport slave (
    input  din, din_valid,
    output din_ready, x, x_valid, busy, word_done, match_exp
  );
`endif
endinterface

// File: rtl/seq_bit_tx.sv
// rtl/seq_bit_tx.sv - word-to-bit serialiser with golden "1011" match pulse for detector benches.
// Defining SEQ_BIT_TX_CNT_EN adds a saturating 16-bit match counter.
module seq_bit_tx #(
  parameter int WIDTH      = 8,
  parameter int GAP_CYCLES = 0,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  seq_bit_tx_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [4:0] LAST_IDX = 5'(WIDTH - 1);
  localparam logic [3:0] GAP_LAST = 4'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);
  localparam bit         HAS_GAP  = (GAP_CYCLES != 0);

  state_t           state_q;
  logic [WIDTH-1:0] sh_q;
  logic [4:0]       cnt_q;
  logic [3:0]       gap_q;
  logic             x_q;
  logic             x_valid_q;
  logic             word_done_q;
  // Only the three most recent bits need storing; the fourth is the live x.
  logic [2:0]       hist_q;

  logic din_ready_d;
  logic take_d;

  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  // Accepting during the final bit is what lets back-to-back words run bubble-free.
  assign din_ready_d = (state_q == IDLE) ||
                       ((state_q == SHIFT) && (cnt_q == 5'd0) && !HAS_GAP);
  assign take_d      = bus.din_valid && din_ready_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sh_q        <= '0;
      cnt_q       <= 5'd0;
      gap_q       <= 4'd0;
      x_q         <= 1'b0;
      x_valid_q   <= 1'b0;
      word_done_q <= 1'b0;
      hist_q      <= 3'd0;
    end else begin
      word_done_q <= 1'b0;
      if (x_valid_q) begin
        hist_q <= {hist_q[1:0], x_q};
      end
      if (take_d) begin
        state_q     <= SHIFT;
        x_q         <= head_bit(bus.din);
        x_valid_q   <= 1'b1;
        sh_q        <= advance(bus.din);
        cnt_q       <= LAST_IDX;
        word_done_q <= (WIDTH == 1);
      end else begin
        case (state_q)
          IDLE: begin
            x_q       <= 1'b0;
            x_valid_q <= 1'b0;
          end
          SHIFT: begin
            if (cnt_q != 5'd0) begin
              x_q         <= head_bit(sh_q);
              sh_q        <= advance(sh_q);
              cnt_q       <= cnt_q - 5'd1;
              word_done_q <= (cnt_q == 5'd1);
            end else begin
              x_q       <= 1'b0;
              x_valid_q <= 1'b0;
              if (HAS_GAP) begin
                state_q <= GAP;
                gap_q   <= GAP_LAST;
              end else begin
                state_q <= IDLE;
              end
            end
          end
          GAP: begin
            if (gap_q == 4'd0) begin
              state_q <= IDLE;
            end else begin
              gap_q <= gap_q - 4'd1;
            end
          end
          default: begin
            state_q   <= IDLE;
            x_q       <= 1'b0;
            x_valid_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.din_ready = din_ready_d;
  assign bus.x         = x_q;
  assign bus.x_valid   = x_valid_q;
  assign bus.word_done = word_done_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.match_exp = x_valid_q && ({hist_q, x_q} == 4'b1011);

`ifdef SEQ_BIT_TX_CNT_EN
  logic [15:0] match_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_cnt_q <= 16'd0;
    end else if (bus.match_exp && (match_cnt_q != 16'hFFFF)) begin
      match_cnt_q <= match_cnt_q + 16'd1;
    end
  end

  assign bus.match_cnt = match_cnt_q;
`endif

endmodule
